gate_sweep_checker: RTL and testbench
=====================================

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 2: cycles each input vector is driven before the gate output is sampled; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a sweep; sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 3 bits: gate under test (0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6-7 illegal); captured when start is accepted.
REQ-006 The block SHALL have port a, output, 1 bit: registered drive to the gate's first input.
REQ-007 The block SHALL have port b, output, 1 bit: registered drive to the gate's second input.
REQ-008 The block SHALL have port c, input, 1 bit: gate output returned from the device under test.
REQ-009 The block SHALL have port busy, output, 1 bit: high from the cycle after start is accepted through the final SAMPLE cycle.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse at sweep end.
REQ-011 The block SHALL have port pass, output, 1 bit: high when the last sweep had zero mismatches.
REQ-012 The block SHALL have port err_cnt, output, 3 bits: mismatch count of the last sweep, 0..4.
REQ-013 The block SHALL have port fail_vec, output, 4 bits: bit k set when vector k ({a,b}=k) mismatched.

Function
REQ-014 The block SHALL implement the FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 In IDLE with start=1, the block SHALL capture op, set {a,b}=2'b00, clear vector index, hold counter, err_cnt, fail_vec and pass, and enter DRIVE.
REQ-016 In DRIVE, the hold counter SHALL increment each cycle and the block SHALL enter SAMPLE after exactly HOLD_CYCLES cycles.
REQ-017 SAMPLE SHALL last one cycle, comparing c against the expected value for {a,b} and captured op; on mismatch, err_cnt SHALL increment and fail_vec[index] SHALL be set.
REQ-018 After SAMPLE, if index<3 the block SHALL increment the index, drive {a,b}=index+1, clear the hold counter and return to DRIVE; if index==3 it SHALL enter DONE.
REQ-019 The vector order SHALL be 00, 01, 10, 11; a and b SHALL change only on SAMPLE-to-DRIVE transitions or on start acceptance.
REQ-020 Vector k SHALL be sampled in cycle (k+1)*(HOLD_CYCLES+1) after the start-accepting edge, and done SHALL be high in cycle 4*(HOLD_CYCLES+1)+1.
REQ-021 DONE SHALL last one cycle with done=1 and pass=(err_cnt==0), then return to IDLE.
REQ-022 An illegal op (6 or 7) SHALL bypass the sweep: the next cycle SHALL be DONE with err_cnt=4, fail_vec=4'b1111 and pass=0.
REQ-023 start SHALL be ignored outside IDLE; start held high SHALL restart a sweep on the cycle after DONE.
REQ-024 pass, err_cnt and fail_vec SHALL hold their values until the next accepted start.
REQ-025 err_cnt SHALL saturate at 4; no wrap is permitted.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, and a, b, busy, done, pass, err_cnt, fail_vec, the index and the hold counter SHALL all be 0.
REQ-027 Reset asserted mid-sweep SHALL abort with no done pulse; operation SHALL resume on the first rising edge after rst_n rises.

Structure
REQ-028 A shared package gate_sweep_pkg SHALL hold the op code constants, the FSM state encoding and NUM_VECTORS=4.
REQ-029 A combinational sub-module gate_ref_model (inputs op, a, b; output expected) SHALL compute the expected value; the FSM, counters and result registers SHALL live in gate_sweep_checker.

Verification
REQ-030 op=3 (NOR) with a correct NOR DUT, HOLD_CYCLES=2: done at cycle 13, pass=1, err_cnt=0, fail_vec=0000.
REQ-031 op=3 with the DUT replaced by an OR gate: pass=0, err_cnt=4, fail_vec=1111.
REQ-032 op=4 (XOR) with c stuck at 0: err_cnt=2, fail_vec=0110, pass=0.
REQ-033 op=7: done one cycle after acceptance, err_cnt=4, fail_vec=1111, no a/b toggling.
REQ-034 rst_n pulsed low during vector 2 DRIVE: all outputs 0 immediately, no done; the next start with op=0 on an AND DUT gives pass=1.
REQ-035 start pulsed mid-sweep is ignored (done count stays 1); start held high gives back-to-back sweeps separated by one IDLE cycle.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the two-input gate sweep checker: op codes,
// FSM state encoding and the number of input vectors per sweep.
package gate_sweep_pkg;

    localparam int NUM_VECTORS = 4;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    // Codes 6 and 7 name no gate and skip the sweep entirely.
    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_XNOR;
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model: the value a correct gate of type op
// must produce for inputs a and b.
module gate_ref_model
    import gate_sweep_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       expected
);

    always_comb begin
        expected = 1'b0;
        case (op)
            OP_AND:  expected = a & b;
            OP_OR:   expected = a | b;
            OP_NAND: expected = ~(a & b);
            OP_NOR:  expected = ~(a | b);
            OP_XOR:  expected = a ^ b;
            OP_XNOR: expected = ~(a ^ b);
            default: expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives all four {a,b} vectors into an external gate, holds each for
// HOLD_CYCLES, samples the returned c and accumulates mismatch results.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_vec
);

    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);
    localparam logic [2:0] ERR_MAX    = 3'(NUM_VECTORS);
    localparam logic [1:0] LAST_INDEX = 2'(NUM_VECTORS - 1);

    state_t     state;
    logic [2:0] op_q;
    logic [1:0] index;
    logic [3:0] hold;
    logic       expected;
    logic       mismatch;
    logic [2:0] err_next;

    gate_ref_model u_ref (
        .op       (op_q),
        .a        (a),
        .b        (b),
        .expected (expected)
    );

    assign mismatch = (c != expected);
    assign err_next = (mismatch && (err_cnt < ERR_MAX)) ? err_cnt + 3'd1 : err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= 3'd0;
            a        <= 1'b0;
            b        <= 1'b0;
            index    <= 2'd0;
            hold     <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 3'd0;
            fail_vec <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        {a, b} <= 2'b00;
                        index  <= 2'd0;
                        hold   <= 4'd0;
                        pass   <= 1'b0;
                        if (op_is_legal(op)) begin
                            err_cnt  <= 3'd0;
                            fail_vec <= 4'd0;
                            busy     <= 1'b1;
                            state    <= DRIVE;
                        end else begin
                            err_cnt  <= ERR_MAX;
                            fail_vec <= 4'b1111;
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DRIVE: begin
                    hold <= hold + 4'd1;
                    if (hold == HOLD_LAST) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    err_cnt <= err_next;
                    if (mismatch) begin
                        fail_vec[index] <= 1'b1;
                    end
                    // pass must already reflect this final sample during DONE.
                    if (index == LAST_INDEX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 3'd0);
                        state <= DONE;
                    end else begin
                        index  <= index + 2'd1;
                        {a, b} <= index + 2'd1;
                        hold   <= 4'd0;
                        state  <= DRIVE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench: a per-cycle behavioural model of the sweep plus
// directed scenarios with hand-computed results.
module tb_gate_sweep_checker;

    localparam int HOLD = 2;
    localparam int HP   = HOLD + 1;

    localparam int MODE_GOOD   = 0;
    localparam int MODE_OR     = 1;
    localparam int MODE_STUCK0 = 2;
    localparam int MODE_AND    = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic       a, b, c;
    logic       busy, done, pass;
    logic [2:0] err_cnt;
    logic [3:0] fail_vec;

    int gate_mode = MODE_GOOD;
    int checks = 0;
    int errors = 0;

    gate_sweep_checker #(.HOLD_CYCLES(HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .c        (c),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_vec (fail_vec)
    );

    always #5 clk = ~clk;

    // Truth tables indexed by k = {a,b}.
    function automatic logic [3:0] goldenTable(input logic [2:0] o);
        case (o)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b1110;
            3'd2:    return 4'b0111;
            3'd3:    return 4'b0001;
            3'd4:    return 4'b0110;
            3'd5:    return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] dutTable(input int mode, input logic [2:0] o);
        case (mode)
            MODE_OR:     return 4'b1110;
            MODE_STUCK0: return 4'b0000;
            MODE_AND:    return 4'b1000;
            default:     return goldenTable(o);
        endcase
    endfunction

    function automatic logic [3:0] expectedMismatch(input logic [2:0] o, input int mode);
        if (o > 3'd5) return 4'b1111;
        return goldenTable(o) ^ dutTable(mode, o);
    endfunction

    logic [3:0] c_tbl;
    assign c_tbl = dutTable(gate_mode, op);
    assign c     = c_tbl[{a, b}];

    // Sweep-level model: cycle number since the accepting edge plus the
    // whole sweep's mismatch mask, worked out once at acceptance.
    int         m_cyc = 0;
    logic [2:0] m_op  = 3'd0;
    logic [3:0] m_mis = 4'd0;
    logic       m_ran = 1'b0;

    function automatic int sweepLen(input logic [2:0] o);
        return (o <= 3'd5) ? 4 * HP + 1 : 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= 0;
            m_op  <= 3'd0;
            m_mis <= 4'd0;
            m_ran <= 1'b0;
        end else if (m_cyc == 0) begin
            if (start) begin
                m_cyc <= 1;
                m_op  <= op;
                m_mis <= expectedMismatch(op, gate_mode);
                m_ran <= 1'b1;
            end
        end else if (m_cyc >= sweepLen(m_op)) begin
            m_cyc <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareCycle();
        logic       legal;
        logic       e_busy, e_done, e_pass;
        logic [1:0] e_ab;
        logic [3:0] e_fv;
        legal  = (m_op <= 3'd5);
        e_busy = 1'b0;
        e_done = 1'b0;
        e_pass = 1'b0;
        e_ab   = 2'd0;
        e_fv   = 4'd0;
        if (m_cyc == 0) begin
            e_fv   = m_mis;
            e_pass = m_ran && (m_mis == 4'd0);
            e_ab   = (m_ran && legal) ? 2'd3 : 2'd0;
        end else if (!legal) begin
            e_done = 1'b1;
            e_fv   = 4'b1111;
        end else begin
            e_busy = (m_cyc <= 4 * HP);
            e_done = (m_cyc == 4 * HP + 1);
            e_ab   = e_busy ? 2'((m_cyc - 1) / HP) : 2'd3;
            for (int k = 0; k < 4; k++) begin
                if (((k + 1) * HP < m_cyc) && m_mis[k]) e_fv[k] = 1'b1;
            end
            e_pass = e_done && (m_mis == 4'd0);
        end
        checkOutput("cyc_busy", 32'(busy), 32'(e_busy));
        checkOutput("cyc_done", 32'(done), 32'(e_done));
        checkOutput("cyc_pass", 32'(pass), 32'(e_pass));
        checkOutput("cyc_ab", 32'({a, b}), 32'(e_ab));
        checkOutput("cyc_fail_vec", 32'(fail_vec), 32'(e_fv));
        checkOutput("cyc_err_cnt", 32'(err_cnt), 32'($countones(e_fv)));
    endtask

    task automatic compareLoop();
        forever begin
            @(negedge clk);
            compareCycle();
        end
    endtask

    // Returns at the negedge of cycle 1 after the accepting edge.
    task automatic applyStimulus(input logic [2:0] o, input int mode);
        @(negedge clk);
        op        = o;
        gate_mode = mode;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout actual=%0d cycles expected=done pulse", cyc);
        end
    endtask

    int dc, d1, d2, cnt;

    initial begin
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        checkOutput("reset_ab_busy_done", 32'({a, b, busy, done}), 32'd0);
        checkOutput("reset_results", 32'({pass, err_cnt, fail_vec}), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        fork
            compareLoop();
        join_none

        // NOR gate, correct DUT
        applyStimulus(3'd3, MODE_GOOD);
        waitDone(dc);
        checkOutput("nor_done_cycle", 32'(dc), 32'd13);
        checkOutput("nor_pass", 32'(pass), 32'd1);
        checkOutput("nor_err", 32'(err_cnt), 32'd0);
        checkOutput("nor_fv", 32'(fail_vec), 32'd0);

        // NOR expected, OR gate present
        applyStimulus(3'd3, MODE_OR);
        waitDone(dc);
        checkOutput("nor_or_pass", 32'(pass), 32'd0);
        checkOutput("nor_or_err", 32'(err_cnt), 32'd4);
        checkOutput("nor_or_fv", 32'(fail_vec), 32'hF);

        // XOR with c stuck at 0
        applyStimulus(3'd4, MODE_STUCK0);
        waitDone(dc);
        checkOutput("xor_stuck_err", 32'(err_cnt), 32'd2);
        checkOutput("xor_stuck_fv", 32'(fail_vec), 32'b0110);
        checkOutput("xor_stuck_pass", 32'(pass), 32'd0);

        // Illegal op bypasses the sweep
        applyStimulus(3'd7, MODE_GOOD);
        waitDone(dc);
        checkOutput("illegal_done_cycle", 32'(dc), 32'd1);
        checkOutput("illegal_err", 32'(err_cnt), 32'd4);
        checkOutput("illegal_fv", 32'(fail_vec), 32'hF);
        checkOutput("illegal_ab", 32'({a, b}), 32'd0);

        // Reset during vector 2 DRIVE
        applyStimulus(3'd0, MODE_AND);
        repeat (6) @(negedge clk);
        checkOutput("pre_reset_ab", 32'({a, b}), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_ab_busy_done", 32'({a, b, busy, done}), 32'd0);
        checkOutput("midreset_results", 32'({pass, err_cnt, fail_vec}), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        checkOutput("midreset_no_done", 32'(cnt), 32'd0);
        applyStimulus(3'd0, MODE_AND);
        waitDone(dc);
        checkOutput("and_after_reset_cycle", 32'(dc), 32'd13);
        checkOutput("and_after_reset_pass", 32'(pass), 32'd1);

        // start pulsed mid-sweep is ignored
        applyStimulus(3'd1, MODE_GOOD);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        checkOutput("midstart_done_count", 32'(cnt), 32'd1);

        // start held high: back-to-back sweeps
        @(negedge clk);
        op        = 3'd5;
        gate_mode = MODE_GOOD;
        start     = 1'b1;
        dc = 0;
        d1 = -1;
        d2 = -1;
        while (d2 < 0 && dc < 100) begin
            @(negedge clk);
            dc++;
            if (done === 1'b1) begin
                if (d1 < 0) d1 = dc;
                else d2 = dc;
            end
        end
        start = 1'b0;
        checkOutput("b2b_first_done", 32'(d1), 32'd13);
        checkOutput("b2b_gap", 32'(d2 - d1), 32'(4 * HP + 2));

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
